// File: rtl/slide_window_ctrl.sv
// slide_window_ctrl: maps VGA hcount/vcount onto one positioned image window
// in a deck of slides stored in ROM, and emits the registered RGB332 pixel.
// Ports: clk, reset (sync, active-high). From the timing generator: hcount,
// vcount, hsync_in, vsync_in. slide_next/slide_prev are one-cycle requests.
// x0/y0 set the window origin. rom_addr/rom_data is the image ROM port; the
// ROM read is combinational. rgb, hsync_out and vsync_out go to the output
// pins. slide_idx is the slide on screen. frame_start pulses after a commit.
// All outputs lag the counters by 2 cycles.
module slide_window_ctrl #(
   parameter int         IMG_W      = 168,
   parameter int         IMG_H      = 192,
   parameter int         NUM_SLIDES = 4,
   parameter int         ADDR_W     = 18,
   parameter int         H_ACTIVE   = 800,
   parameter int         V_ACTIVE   = 600,
   parameter int         H_TOTAL    = 1056,
   parameter int         V_TOTAL    = 628,
   parameter logic [7:0] BG_COLOR   = 8'h04
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              slide_next,
   input  logic              slide_prev,
   input  logic [10:0]       x0,
   input  logic [9:0]        y0,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        rgb,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic [3:0]        slide_idx,
   output logic              frame_start
);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [11:0] W12    = 12'(IMG_W);
   localparam logic [10:0] H11    = 11'(IMG_H);
   localparam logic [3:0]  LAST_IDX = 4'(NUM_SLIDES - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] SLIDE_SZ  = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] LAST_BASE =
      ADDR_W'((NUM_SLIDES - 1) * IMG_W * IMG_H);

   typedef enum logic {S_WAIT_FRAME, S_RUN} state_t;
   typedef enum logic [1:0] {P_NONE, P_NEXT, P_PREV} pend_t;

   state_t            r_state;
   pend_t             r_pend;
   logic [3:0]        r_slide;
   logic [ADDR_W-1:0] r_sbase;
   logic [ADDR_W-1:0] r_lbase;
   logic [10:0]       r_x0;
   logic [9:0]        r_y0;
   logic [ADDR_W-1:0] r_addr;
   logic              r_hit1;
   logic              r_act1;
   logic [7:0]        r_rgb;
   logic [1:0]        r_hs;
   logic [1:0]        r_vs;
   logic              r_fs;

   logic              w_fb;
   logic              w_run;
   logic [11:0]       w_xend;
   logic [10:0]       w_yend;
   logic              w_in_x;
   logic              w_in_y;
   logic              w_act;
   logic              w_hit;
   logic              w_last_col;
   logic [10:0]       w_col;
   pend_t             w_pend;
   logic [3:0]        w_idx_n;
   logic [ADDR_W-1:0] w_base_n;

   always_comb begin
      w_fb   = (hcount == H_LAST) && (vcount == V_LAST);
      w_run  = (r_state == S_RUN);
      w_xend = {1'b0, r_x0} + W12;
      w_yend = {1'b0, r_y0} + H11;
      w_in_x = (hcount >= r_x0) && ({1'b0, hcount} < w_xend);
      w_in_y = (vcount >= r_y0) && ({1'b0, vcount} < w_yend);
      w_act  = (hcount < H_ACT) && (vcount < V_ACT);
      w_hit  = w_in_x && w_in_y && w_act;
      // Last window column of a window line, clipped or not: the line
      // base must still step so lower lines keep their addresses.
      w_last_col = w_in_y && ({1'b0, hcount} == w_xend - 12'd1);
      w_col  = hcount - r_x0;

      // A request seen in the FB cycle survives into the next frame.
      unique case (1'b1)
         slide_next && !slide_prev: w_pend = P_NEXT;
         slide_prev && !slide_next: w_pend = P_PREV;
         default:                   w_pend = w_fb ? P_NONE : r_pend;
      endcase

      w_idx_n  = r_slide;
      w_base_n = r_sbase;
      unique case (r_pend)
         P_NEXT: begin
            if (r_slide == LAST_IDX) begin
               w_idx_n  = '0;
               w_base_n = '0;
            end else begin
               w_idx_n  = r_slide + 4'd1;
               w_base_n = r_sbase + SLIDE_SZ;
            end
         end
         P_PREV: begin
            if (r_slide == '0) begin
               w_idx_n  = LAST_IDX;
               w_base_n = LAST_BASE;
            end else begin
               w_idx_n  = r_slide - 4'd1;
               w_base_n = r_sbase - SLIDE_SZ;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_WAIT_FRAME;
         r_pend  <= P_NONE;
         r_slide <= '0;
         r_sbase <= '0;
         r_lbase <= '0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_addr  <= '0;
         r_hit1  <= 1'b0;
         r_act1  <= 1'b0;
         r_rgb   <= '0;
         r_hs    <= 2'b11;
         r_vs    <= 2'b11;
         r_fs    <= 1'b0;
      end else begin
         r_hs   <= {r_hs[0], hsync_in};
         r_vs   <= {r_vs[0], vsync_in};
         r_fs   <= w_fb;
         r_pend <= w_pend;
         r_hit1 <= w_run && w_hit;
         r_act1 <= w_run && w_act;

         if (r_hit1)
            r_rgb <= rom_data;
         else if (r_act1)
            r_rgb <= BG_COLOR;
         else
            r_rgb <= '0;

         if (w_run && w_hit)
            r_addr <= r_lbase + ADDR_W'(w_col);

         if (w_fb) begin
            r_state <= S_RUN;
            r_slide <= w_idx_n;
            r_sbase <= w_base_n;
            r_lbase <= w_base_n;
            r_x0    <= x0;
            r_y0    <= y0;
         end else if (w_last_col) begin
            r_lbase <= r_lbase + LINE_STEP;
         end
      end
   end

   assign rom_addr    = r_addr;
   assign rgb         = r_rgb;
   assign hsync_out   = r_hs[1];
   assign vsync_out   = r_vs[1];
   assign slide_idx   = r_slide;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_slide_window_ctrl.sv
// tb_slide_window_ctrl: directed vectors for slide_window_ctrl; the bench
// drives hcount/vcount directly and jumps to the frame-boundary pixel.
module tb_slide_window_ctrl;

   localparam logic [10:0] FH = 11'd1000;
   localparam logic [9:0]  FV = 10'd620;

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic [17:0] addr;
      logic [7:0]  rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync_in;
   logic        vsync_in;
   logic        slide_next;
   logic        slide_prev;
   logic [10:0] x0;
   logic [9:0]  y0;
   logic [17:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  rgb;
   logic        hsync_out;
   logic        vsync_out;
   logic [3:0]  slide_idx;
   logic        frame_start;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   slide_window_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .slide_next  (slide_next),
      .slide_prev  (slide_prev),
      .x0          (x0),
      .y0          (y0),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .rgb         (rgb),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .slide_idx   (slide_idx),
      .frame_start (frame_start)
   );

   function automatic logic [7:0] romv(input logic [17:0] a);
      return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'hA5;
   endfunction

   assign rom_data = romv(rom_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [10:0] h, input logic [9:0] v,
                      input logic nx, input logic pv);
      hcount     = h;
      vcount     = v;
      slide_next = nx;
      slide_prev = pv;
      @(posedge clk);
      #1;
      slide_next = 1'b0;
      slide_prev = 1'b0;
   endtask

   task automatic run_vec(input vec_t t, input string tag);
      cyc(t.h, t.v, 1'b0, 1'b0);
      chk({tag, " addr"}, 32'(rom_addr), 32'(t.addr));
      cyc(FH, FV, 1'b0, 1'b0);
      chk({tag, " rgb"}, 32'(rgb), 32'(t.rgb));
   endtask

   task automatic do_fb(input logic nx, input logic pv,
                        input logic [3:0] exp_idx, input string tag);
      cyc(11'd1055, 10'd627, nx, pv);
      chk({tag, " fs"}, 32'(frame_start), 32'd1);
      chk({tag, " idx"}, 32'(slide_idx), 32'(exp_idx));
      cyc(FH, FV, 1'b0, 1'b0);
      chk({tag, " fs_lo"}, 32'(frame_start), 32'd0);
   endtask

   vec_t tw[3];
   vec_t ta[5];
   vec_t tb[5];
   vec_t tc[6];
   logic [7:0] hp;
   logic [7:0] vp;

   initial begin
      tw[0] = '{11'd10,  10'd10,  18'd0, 8'h00};
      tw[1] = '{11'd100, 10'd50,  18'd0, 8'h00};
      tw[2] = '{11'd500, 10'd300, 18'd0, 8'h00};

      ta[0] = '{11'd10,  10'd10, 18'd0,   romv(18'd0)};
      ta[1] = '{11'd177, 10'd10, 18'd167, romv(18'd167)};
      ta[2] = '{11'd9,   10'd10, 18'd167, 8'h04};
      ta[3] = '{11'd800, 10'd10, 18'd167, 8'h00};
      ta[4] = '{11'd10,  10'd11, 18'd168, romv(18'd168)};

      tb[0] = '{11'd10,  10'd201, 18'd32088, romv(18'd32088)};
      tb[1] = '{11'd177, 10'd201, 18'd32255, romv(18'd32255)};
      tb[2] = '{11'd100, 10'd202, 18'd32255, 8'h04};
      tb[3] = '{11'd178, 10'd100, 18'd32255, 8'h04};
      tb[4] = '{11'd100, 10'd600, 18'd32255, 8'h00};

      tc[0] = '{11'd700, 10'd500, 18'd32256, romv(18'd32256)};
      tc[1] = '{11'd799, 10'd500, 18'd32355, romv(18'd32355)};
      tc[2] = '{11'd800, 10'd500, 18'd32355, 8'h00};
      tc[3] = '{11'd867, 10'd500, 18'd32355, 8'h00};
      tc[4] = '{11'd700, 10'd501, 18'd32424, romv(18'd32424)};
      tc[5] = '{11'd699, 10'd501, 18'd32424, 8'h04};

      hp = 8'b1011_0010;
      vp = 8'b0110_1001;

      reset      = 1'b1;
      hcount     = FH;
      vcount     = FV;
      hsync_in   = 1'b0;
      vsync_in   = 1'b0;
      slide_next = 1'b0;
      slide_prev = 1'b0;
      x0         = 11'd10;
      y0         = 10'd10;
      cyc(FH, FV, 1'b0, 1'b0);
      cyc(FH, FV, 1'b0, 1'b0);
      chk("rst addr", 32'(rom_addr), 32'd0);
      chk("rst rgb", 32'(rgb), 32'd0);
      chk("rst hs", 32'(hsync_out), 32'd1);
      chk("rst vs", 32'(vsync_out), 32'd1);
      chk("rst idx", 32'(slide_idx), 32'd0);
      chk("rst fs", 32'(frame_start), 32'd0);
      reset    = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      cyc(FH, FV, 1'b0, 1'b0);

      // first frame stays dark
      for (int i = 0; i < 3; i++) run_vec(tw[i], $sformatf("W%0d", i));
      do_fb(1'b0, 1'b0, 4'd0, "fb1");

      // second frame, x0=y0=10, slide 0
      for (int i = 0; i < 5; i++) run_vec(ta[i], $sformatf("A%0d", i));
      for (int v = 11; v <= 200; v++) cyc(11'd177, 10'(v), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) run_vec(tb[i], $sformatf("B%0d", i));

      // step to slide 3, then wrap forward
      cyc(FH, FV, 1'b1, 1'b0);
      do_fb(1'b0, 1'b0, 4'd1, "n1");
      cyc(FH, FV, 1'b1, 1'b0);
      do_fb(1'b0, 1'b0, 4'd2, "n2");
      cyc(FH, FV, 1'b1, 1'b0);
      do_fb(1'b0, 1'b0, 4'd3, "n3");
      cyc(FH, FV, 1'b1, 1'b0);
      cyc(FH, FV, 1'b0, 1'b0);
      chk("hold idx", 32'(slide_idx), 32'd3);
      chk("hold fs", 32'(frame_start), 32'd0);
      do_fb(1'b0, 1'b0, 4'd0, "wrapn");
      run_vec('{11'd10, 10'd10, 18'd0, romv(18'd0)}, "wrapn px");

      // wrap backward
      cyc(FH, FV, 1'b0, 1'b1);
      do_fb(1'b0, 1'b0, 4'd3, "wrapp");
      run_vec('{11'd10, 10'd10, 18'd96768, romv(18'd96768)}, "wrapp px");

      // simultaneous requests are ignored and keep a pending step
      cyc(FH, FV, 1'b1, 1'b1);
      do_fb(1'b0, 1'b0, 4'd3, "both");
      cyc(FH, FV, 1'b1, 1'b0);
      cyc(FH, FV, 1'b1, 1'b1);
      do_fb(1'b0, 1'b0, 4'd0, "both_keep");

      // last request wins, never more than one step
      cyc(FH, FV, 1'b1, 1'b0);
      cyc(FH, FV, 1'b0, 1'b1);
      do_fb(1'b0, 1'b0, 4'd3, "np");
      for (int k = 0; k < 3; k++) cyc(FH, FV, 1'b1, 1'b0);
      do_fb(1'b0, 1'b0, 4'd0, "nnn");

      // request in the FB cycle applies one frame later
      do_fb(1'b1, 1'b0, 4'd0, "fbreq");
      x0 = 11'd700;
      y0 = 10'd500;
      do_fb(1'b0, 1'b0, 4'd1, "fbreq2");

      // clipped window at slide 1
      for (int i = 0; i < 6; i++) run_vec(tc[i], $sformatf("C%0d", i));
      for (int v = 501; v <= 598; v++) cyc(11'd867, 10'(v), 1'b0, 1'b0);
      run_vec('{11'd799, 10'd599, 18'd48987, romv(18'd48987)}, "C6");
      run_vec('{11'd700, 10'd600, 18'd48987, 8'h00}, "C7");

      // sync delay
      for (int i = 0; i < 8; i++) begin
         hsync_in = hp[i];
         vsync_in = vp[i];
         cyc(FH, FV, 1'b0, 1'b0);
         if (i >= 1) begin
            chk($sformatf("hs%0d", i), 32'(hsync_out), 32'(hp[i-1]));
            chk($sformatf("vs%0d", i), 32'(vsync_out), 32'(vp[i-1]));
         end
      end
      hsync_in = 1'b1;
      vsync_in = 1'b1;

      // reset in mid-frame
      x0 = 11'd10;
      y0 = 10'd290;
      cyc(FH, FV, 1'b1, 1'b0);
      do_fb(1'b0, 1'b0, 4'd2, "pre_rst");
      cyc(11'd100, 10'd300, 1'b1, 1'b0);
      reset = 1'b1;
      cyc(11'd101, 10'd300, 1'b0, 1'b0);
      reset = 1'b0;
      chk("mrst rgb", 32'(rgb), 32'd0);
      chk("mrst idx", 32'(slide_idx), 32'd0);
      chk("mrst addr", 32'(rom_addr), 32'd0);
      run_vec('{11'd100, 10'd300, 18'd0, 8'h00}, "dark");
      do_fb(1'b0, 1'b0, 4'd0, "post_rst");
      run_vec('{11'd10, 10'd290, 18'd0, romv(18'd0)}, "R0");
      for (int v = 290; v <= 299; v++) cyc(11'd177, 10'(v), 1'b0, 1'b0);
      run_vec('{11'd100, 10'd300, 18'd1770, romv(18'd1770)}, "R1");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/slide_window_ctrl.md
Name: slide_window_ctrl

Overview:
- Sequences image-ROM reads for the 800x600 VGA pipeline: converts the timing generator's hcount/vcount into ROM addresses for one positioned image window and emits the registered 8-bit RGB332 pixel.
- Manages a deck of NUM_SLIDES images stored back-to-back in one ROM; next/prev requests take effect only at frame boundaries, so a slide never tears.
- Sits between the sync/counter generator and the RGB/sync output pins.

Parameters:
- IMG_W, 168, window width in pixels
- IMG_H, 192, window height in lines
- NUM_SLIDES, 4, slides in ROM, each IMG_W*IMG_H bytes, slide k at base k*IMG_W*IMG_H
- ADDR_W, 18, ROM address width; must hold NUM_SLIDES*IMG_W*IMG_H-1
- H_ACTIVE, 800 / V_ACTIVE, 600, visible area
- H_TOTAL, 1056 / V_TOTAL, 628, full line/frame counts
- BG_COLOR, 8'h04, colour inside the active area but outside the window

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  11  horizontal counter from the timing generator
- vcount  in  10  vertical counter from the timing generator
- hsync_in  in  1  raw hsync, aligned with hcount
- vsync_in  in  1  raw vsync, aligned with vcount
- slide_next  in  1  one-cycle request: advance one slide
- slide_prev  in  1  one-cycle request: go back one slide
- x0  in  11  window left column; sampled at frame boundary
- y0  in  10  window top line; sampled at frame boundary
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  8  combinational ROM data for rom_addr, same cycle
- rgb  out  8  registered pixel, RGB332
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- slide_idx  out  4  currently displayed slide
- frame_start  out  1  one-cycle pulse when new slide/origin values are committed

Behaviour:
- Reset values: rom_addr=0, rgb=0, hsync_out=1, vsync_out=1, slide_idx=0, frame_start=0, pending request cleared, latched origin x0/y0=0, FSM=WAIT_FRAME.
- Frame boundary (FB): the cycle with hcount==H_TOTAL-1 and vcount==V_TOTAL-1.
- FSM WAIT_FRAME: rgb forced to 0, rom_addr held at 0; go to RUN at the first FB.
- FSM RUN: steady-state operation; stays in RUN until reset.
- At every FB, in both states:
  - Apply the pending request: slide_idx +1 or -1, modulo NUM_SLIDES. NUM_SLIDES-1 +1 wraps to 0; 0 -1 wraps to NUM_SLIDES-1.
  - Clear the pending request.
  - Latch x0 and y0.
  - Set the line base to slide_idx_new*IMG_W*IMG_H.
  - Pulse frame_start on the next cycle.
- Requests, sampled every cycle:
  - slide_next alone sets pending=+1; slide_prev alone sets pending=-1.
  - Both asserted in the same cycle: ignored, pending unchanged.
  - A later request overwrites an earlier one; pending never exceeds one step.
  - A request arriving in the FB cycle itself applies at the next FB.
- Window hit: x0L <= hcount < x0L+IMG_W, y0L <= vcount < y0L+IMG_H, and inside the active area (hcount<H_ACTIVE, vcount<V_ACTIVE).
  - Parts of the window beyond the active area are clipped, but addresses still advance as if the window were drawn in full.
- Address: rom_addr = base + (vcount-y0L)*IMG_W + (hcount-x0L), computed incrementally; no multiplier.
  - The line base advances by IMG_W after the last window column of each window line, even if that column is clipped.
- Pipeline (cycle N = cycle hcount/vcount/syncs are presented):
  - Cycle N+1: rom_addr for pixel N is registered; rom_data is valid combinationally in that cycle.
  - Cycle N+2: rgb is registered.
  - rgb = rom_data on a window hit, BG_COLOR on an active non-hit pixel, 0 outside the active area.
  - hsync_out/vsync_out are the syncs delayed 2 cycles, so total latency is 2 cycles for all outputs.
- On a non-hit pixel, rom_addr holds its last value.
- Reset asserted mid-frame: all state returns to reset values on the next edge and the FSM re-enters WAIT_FRAME. No partial frame is drawn until the following FB.

Test Plan:
- Reset, run 2 frames, x0=10, y0=10, slide 0 -> rgb=0 for the whole first frame. In the second frame:
  - hcount=10, vcount=10 gives rom_addr=0 at N+1 and rgb=rom[0] at N+2.
  - hcount=177, vcount=201 gives rom_addr=32255.
  - hcount=9 gives rgb=8'h04.
  - hcount=800 gives rgb=0.
- slide_next pulsed mid-frame with slide_idx=3 -> slide_idx stays 3 until FB, then becomes 0 with a frame_start pulse; the first window pixel reads rom_addr 0.
- slide_prev at slide 0 -> slide_idx=3 after FB, first window address 96768; slide_next and slide_prev in the same cycle -> no change.
- slide_next then slide_prev in the same frame -> net -1 applied at FB; three slide_next pulses -> only +1 applied.
- x0=700, y0=500 -> columns 800..867 and lines 600..691 are clipped. Line 501 starts at base+168, and hsync_out/vsync_out track the syncs with exactly 2 cycles of delay.
- Reset asserted at vcount=300 -> rgb=0 and slide_idx=0 next cycle; output stays dark until FB, with correct addressing from the following frame.
